// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared 8N1 frame constants and transmitter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Small synchronous FIFO; full/empty decoded from a registered
//               occupancy count so they carry no path from wr_en/rd_en.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // DEPTH is a power of two, so the full count is a single MSB set
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a byte FIFO ahead of the shifter.
//               Back-to-back frames are contiguous; txd and busy registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_CLK    = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txdata,
  input  logic       txvalid,
  output logic       txready,
  output logic       txd,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST = 16'(BIT_CLK - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       push;
  logic       pop;

  tx_state_t   state, state_n;
  logic [7:0]  shift, shift_n;
  logic [15:0] bit_cnt, bit_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        txd_n;
  logic        bit_done;

  // txready depends only on registered FIFO occupancy
  assign txready  = ~fifo_full;
  assign push     = txvalid & ~fifo_full & ~rst;
  assign bit_done = (bit_cnt == BIT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (txdata),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencing: next state, shifter, counters and the next line level
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    txd_n     = txd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txd_n = IDLE_LEVEL;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = fifo_rd_data;
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = START;
          txd_n     = START_LEVEL;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          state_n   = DATA;
          txd_n     = shift[0];
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
          txd_n     = START_LEVEL;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          shift_n   = {1'b0, shift[7:1]};
          if (bit_idx == IDX_LAST) begin
            state_n = STOP;
            txd_n   = STOP_LEVEL;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shift[1];
          end
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          // Chain straight into the next start bit when a byte is waiting
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_n   = fifo_rd_data;
            bit_idx_n = '0;
            state_n   = START;
            txd_n     = START_LEVEL;
          end else begin
            state_n = IDLE;
            txd_n   = IDLE_LEVEL;
          end
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
          txd_n     = STOP_LEVEL;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = IDLE_LEVEL;
      end
    endcase
  end

  // State register; txd is registered here so the line never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      txd     <= IDLE_LEVEL;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
    end
  end

  // busy reflects the previous cycle's state and occupancy
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state != IDLE) || !fifo_empty;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BIT_CLK, default 87, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries buffered ahead of the shifter; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port txdata, input, 8, the byte offered for transmission.
REQ-006 SHALL have port txvalid, input, 1, high when txdata holds a valid byte.
REQ-007 SHALL have port txready, output, 1, high when a byte can be accepted.
REQ-008 SHALL have port txd, output, 1, the serial line toward the receiver; idles high.
REQ-009 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL accept a byte on a rising edge where txvalid and txready are both high; the byte is written into the FIFO.
REQ-011 SHALL drive txready = NOT full, from registered FIFO state only, with no combinational path from txvalid.
REQ-012 SHALL ignore txdata whenever txvalid is low, or when txvalid is high and txready is low; the byte is not written and no state changes.
REQ-013 SHALL use the FSM states IDLE, START, DATA and STOP, with frame format 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-014 IDLE: txd=1; on a cycle where the FIFO is non-empty, pop the head into the shift register, clear the bit counter and bit index, and go to START.
REQ-015 START: txd=0 for exactly BIT_CLK cycles, then go to DATA.
REQ-016 DATA: txd=shift[0] for BIT_CLK cycles per bit; after each bit, shift right and increment the index; after index 7 completes, go to STOP.
REQ-017 STOP: txd=1 for BIT_CLK cycles; at the last STOP cycle, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap; otherwise go to IDLE.
REQ-018 Each frame SHALL occupy exactly 10*BIT_CLK cycles on txd; back-to-back frames SHALL be contiguous.
REQ-019 Latency: with the FIFO empty and the FSM in IDLE, txd SHALL go low in the second cycle after the accepting edge, i.e. 1 cycle in the FIFO plus 1 cycle for the load.
REQ-020 txd SHALL be registered, with no glitches and no combinational path from inputs.
REQ-021 The bit counter SHALL be 16 bits wide and wrap to 0 at BIT_CLK-1; it SHALL never be compared against BIT_CLK itself.
REQ-022 FIFO occupancy SHALL be held as a count of width log2(FIFO_DEPTH)+1; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged, and the data order SHALL be preserved.
REQ-024 Full: txready=0, and a pop in the same cycle SHALL not raise txready until the next cycle.
REQ-025 Empty: a pop SHALL never occur; the FSM stays in IDLE with txd=1.
REQ-026 busy SHALL be registered and high when the state is not IDLE or the count is greater than 0.

Reset
REQ-027 When rst is high at an edge: state=IDLE, txd=1, FIFO count and pointers=0, shift register=0, counters=0, busy=0.
REQ-028 txready SHALL be 1 from the first cycle after reset.
REQ-029 Reset mid-frame SHALL abort the frame: txd=1 from the next cycle, and buffered bytes are discarded.
REQ-030 txvalid SHALL be ignored during any cycle in which rst is high.

Structure
REQ-031 A shared package SHALL hold the frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
REQ-032 The shared package SHALL hold the FSM state encoding, so that uart_rx and uart_tx benches share the frame definition.
REQ-033 The FIFO SHALL be a separate sub-module, uart_tx_fifo (clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty), instantiated once.

Verification (BIT_CLK=4, FIFO_DEPTH=4)
REQ-034 Single byte: push 0xA5 into an idle block -> txd low 2 cycles later, then 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; 40 cycles total; busy falls 1 cycle after the stop bit.
REQ-035 Burst: push 0x00, 0xFF, 0x55, 0x0F, 0x81 with txvalid held -> txready drops once full; all five frames appear contiguous with 200 cycles of txd activity and no idle gap.
REQ-036 Full boundary: fill 4 bytes while the shifter is busy -> txready=0; a byte held on txdata is not lost, and it is accepted on the cycle after a pop.
REQ-037 Reset mid-frame: assert rst during DATA bit 3 of 0x3C with 2 bytes queued -> txd=1 next cycle, busy=0, txready=1, no further frames.
REQ-038 Loopback: connect txd to uart_rx rxd with matching BIT_CLK=87, send 0x00, 0x7E, 0xFF -> rxdata presents each byte in order.
